// File: rtl/alpha_recursion_seq_if.sv
// trellis_if: static trellis description consumed by alpha_recursion_seq.
//   next_states[s][u] : state reached from state s on input bit u
//   outputs[s][u]     : output-symbol index (selects a gamma lane) for that branch
// Both tables must stay constant while a frame is in progress.
interface trellis_if #(
  parameter int STATES          = 4,
  parameter int BITS_PER_SYMBOL = 2
);
  localparam int SW = $clog2(STATES);

  logic [SW-1:0]              next_states [STATES][2];
  logic [BITS_PER_SYMBOL-1:0] outputs     [STATES][2];

  modport sink   (input  next_states, input  outputs);
  modport source (output next_states, output outputs);
endinterface

// File: rtl/alpha_recursion_seq.sv
// alpha_recursion_seq: forward (alpha) max-log recursion over a trellis.
// A frame emits frame_len+1 alpha vectors: the initial vector (index 0),
// then one vector per accepted gamma beat, with one cycle of latency.
//
// Ports
//   clk, reset            : single clock, synchronous active-high reset
//   trellis               : trellis_if.sink, next-state and output-symbol tables
//   start, frame_len      : begin a frame of frame_len steps (IDLE only)
//   in_valid/in_ready     : gamma handshake, gamma = OUTPUT_SYMBOLS branch metrics
//   out_valid/out_ready   : alpha handshake, alpha_out = STATES metrics
//   out_index, out_last   : beat number and last-beat flag
//   busy                  : FSM not in IDLE
//
// Optional build macro ALPHA_NORM_EN: each new alpha vector is shifted so its
// maximum is 0 (NEG entries untouched) before being registered.
//
// state | meaning
// IDLE  | waiting for a valid start
// INIT  | presenting the initial alpha vector (index 0)
// RUN   | accepting gamma beats, one alpha vector per beat
// DRAIN | last vector presented, waiting for it to be taken
module alpha_recursion_seq #(
  parameter int BITS            = 16,
  parameter int STATES          = 4,
  parameter int BITS_PER_SYMBOL = 2,
  parameter int MAX_SYMBOLS     = 1024,
  localparam int OUTPUT_SYMBOLS = 2 ** BITS_PER_SYMBOL,
  localparam int LEN_W          = $clog2(MAX_SYMBOLS + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  trellis_if.sink                              trellis,
  input  logic                                 start,
  input  logic [LEN_W-1:0]                     frame_len,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]  gamma,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [STATES-1:0][BITS-1:0]          alpha_out,
  output logic [LEN_W-1:0]                     out_index,
  output logic                                 out_last,
  output logic                                 busy
);
  localparam int SW = $clog2(STATES);
  localparam logic signed [BITS-1:0] NEG  = {1'b1, {(BITS-1){1'b0}}};
  localparam logic signed [BITS-1:0] MAXV = {1'b0, {(BITS-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, INIT, RUN, DRAIN} state_t;

  state_t                      state, state_d;
  logic [LEN_W-1:0]            len_q;
  logic [STATES-1:0][BITS-1:0] alpha_q, alpha_init, alpha_nxt;
  logic signed [BITS-1:0]      alpha_raw [STATES];
  logic signed [BITS-1:0]      cand, row_max;
  logic                        found;
  logic                        start_ok, last_step, accept;

  // Overflow shows up as disagreement between the two top bits of the
  // one-bit-wider result; the top bit then gives the direction.
  function automatic logic signed [BITS-1:0] sat_add(input logic signed [BITS-1:0] a,
                                                    input logic signed [BITS-1:0] b);
    logic [BITS:0] s;
    s = {a[BITS-1], a} + {b[BITS-1], b};
    if (s[BITS] != s[BITS-1]) return s[BITS] ? NEG : MAXV;
    return s[BITS-1:0];
  endfunction

  function automatic logic signed [BITS-1:0] sat_sub(input logic signed [BITS-1:0] a,
                                                    input logic signed [BITS-1:0] b);
    logic [BITS:0] s;
    s = {a[BITS-1], a} - {b[BITS-1], b};
    if (s[BITS] != s[BITS-1]) return s[BITS] ? NEG : MAXV;
    return s[BITS-1:0];
  endfunction

  assign alpha_out = alpha_q;
  assign busy      = (state != IDLE);
  assign start_ok  = start && (frame_len != '0) && (frame_len <= LEN_W'(MAX_SYMBOLS));
  assign last_step = ((out_index + LEN_W'(1)) == len_q);
  assign accept    = in_valid && in_ready;

  always_comb begin
    alpha_init = '0;
    for (int s = 1; s < STATES; s++) alpha_init[s] = NEG;
  end

  // Gather over all branches entering each state. Strict '>' keeps the first
  // maximum found in (s major, u minor) order; a state with no incoming branch
  // stays at NEG.
  always_comb begin
    cand  = NEG;
    found = 1'b0;
    for (int sp = 0; sp < STATES; sp++) begin
      alpha_raw[sp] = NEG;
      found         = 1'b0;
      for (int s = 0; s < STATES; s++) begin
        for (int u = 0; u < 2; u++) begin
          if (trellis.next_states[s][u] == SW'(sp)) begin
            cand = sat_add($signed(alpha_q[s]), $signed(gamma[trellis.outputs[s][u]]));
            if (!found || (cand > alpha_raw[sp])) begin
              alpha_raw[sp] = cand;
              found         = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    row_max   = NEG;
    alpha_nxt = '0;
`ifdef ALPHA_NORM_EN
    for (int sp = 0; sp < STATES; sp++)
      if (alpha_raw[sp] > row_max) row_max = alpha_raw[sp];
    for (int sp = 0; sp < STATES; sp++)
      alpha_nxt[sp] = (alpha_raw[sp] == NEG) ? NEG : sat_sub(alpha_raw[sp], row_max);
`else
    for (int sp = 0; sp < STATES; sp++) alpha_nxt[sp] = alpha_raw[sp];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // out_valid is always high in INIT and DRAIN, so out_ready alone marks
  // acceptance of the presented beat there.
  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_d = INIT;
      INIT:  if (out_ready) state_d = RUN;
      RUN: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && last_step) state_d = DRAIN;
      end
      DRAIN: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alpha_q   <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_last  <= 1'b0;
      len_q     <= '0;
    end else begin
      case (state)
        IDLE: if (start_ok) begin
          alpha_q   <= alpha_init;
          out_valid <= 1'b1;
          out_index <= '0;
          out_last  <= 1'b0;
          len_q     <= frame_len;
        end
        INIT: if (out_ready) out_valid <= 1'b0;
        RUN: begin
          if (accept) begin
            alpha_q   <= alpha_nxt;
            out_valid <= 1'b1;
            out_index <= out_index + LEN_W'(1);
            out_last  <= last_step;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        DRAIN: if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alpha_recursion_seq.sv
module tb_alpha_recursion_seq;
  localparam int BITS  = 16;
  localparam int STATES = 4;
  localparam int BPS   = 2;
  localparam int OS    = 4;
  localparam int MAXS  = 1024;
  localparam int LEN_W = 11;
  localparam int NEG_I = -32768;
  localparam int MAX_I = 32767;
  localparam int LIMIT = 2000;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      start;
  logic [LEN_W-1:0]          frame_len;
  logic                      in_valid;
  logic                      in_ready;
  logic [OS-1:0][BITS-1:0]   gamma;
  logic                      out_valid;
  logic                      out_ready;
  logic [STATES-1:0][BITS-1:0] alpha_out;
  logic [LEN_W-1:0]          out_index;
  logic                      out_last;
  logic                      busy;

  trellis_if #(.STATES(STATES), .BITS_PER_SYMBOL(BPS)) trel ();

  alpha_recursion_seq #(.BITS(BITS), .STATES(STATES), .BITS_PER_SYMBOL(BPS),
                        .MAX_SYMBOLS(MAXS)) dut (
    .clk(clk), .reset(reset), .trellis(trel), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_ready(in_ready), .gamma(gamma),
    .out_valid(out_valid), .out_ready(out_ready), .alpha_out(alpha_out),
    .out_index(out_index), .out_last(out_last), .busy(busy));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int ns_m [STATES][2];
  int os_m [STATES][2];
  int gam  [64][OS];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  function automatic int sat(input int v);
    if (v > MAX_I) return MAX_I;
    if (v < NEG_I) return NEG_I;
    return v;
  endfunction

  // kind 0: shift-register trellis; kind 1: every branch lands on state u,
  // so states 2 and 3 have no predecessors and ties are common.
  task automatic set_trellis(input int kind);
    for (int s = 0; s < STATES; s++)
      for (int u = 0; u < 2; u++) begin
        if (kind == 0) begin
          ns_m[s][u] = ((s << 1) | u) & 3;
          os_m[s][u] = (s * 2 + u * 3) % 4;
        end else begin
          ns_m[s][u] = u;
          os_m[s][u] = (s + u) % 4;
        end
        trel.next_states[s][u] = 2'(ns_m[s][u]);
        trel.outputs[s][u]     = 2'(os_m[s][u]);
      end
  endtask

  task automatic run_frame(input int len, input int gmode, input int rdy_pct,
                           input int vld_pct, input bit noise, input int abort_at);
    logic [63:0] eq[$];
    logic [63:0] pv, prev_alpha;
    logic [11:0] prev_il;
    int a [STATES];
    int nw [STATES];
    bit has [STATES];
    int beats, steps, cyc, c_first, c_last, t, c, m;
    bit prev_stall, aborted;

    for (int k = 0; k < len; k++)
      for (int j = 0; j < OS; j++)
        case (gmode)
          0: gam[k][j] = int'($urandom_range(0, 200)) - 100;
          1: gam[k][j] = j;
          2: gam[k][j] = 0;
          3: gam[k][j] = MAX_I;
          default: gam[k][j] = int'($urandom_range(0, 65535)) - 32768;
        endcase

    // Reference: scatter each branch candidate into its destination state.
    for (int k = 0; k <= len; k++) begin
      if (k == 0) begin
        for (int s = 0; s < STATES; s++) a[s] = (s == 0) ? 0 : NEG_I;
      end else begin
        for (int s = 0; s < STATES; s++) begin nw[s] = NEG_I; has[s] = 0; end
        for (int s = 0; s < STATES; s++)
          for (int u = 0; u < 2; u++) begin
            t = ns_m[s][u];
            c = sat(a[s] + gam[k-1][os_m[s][u]]);
            if (!has[t] || c > nw[t]) nw[t] = c;
            has[t] = 1;
          end
`ifdef ALPHA_NORM_EN
        m = NEG_I;
        for (int s = 0; s < STATES; s++) if (nw[s] > m) m = nw[s];
        if (m != NEG_I)
          for (int s = 0; s < STATES; s++) if (nw[s] != NEG_I) nw[s] = sat(nw[s] - m);
`endif
        for (int s = 0; s < STATES; s++) a[s] = nw[s];
      end
      pv = '0;
      for (int s = 0; s < STATES; s++) pv[s*BITS +: BITS] = a[s][BITS-1:0];
      eq.push_back(pv);
    end

    @(negedge clk);
    start = 1'b1;
    frame_len = LEN_W'(len);
    @(negedge clk);
    start = 1'b0;
    beats = 0; steps = 0; cyc = 0; c_first = 0; c_last = 0;
    prev_stall = 0; aborted = 0; prev_alpha = '0; prev_il = '0;

    while (beats <= len && cyc < LIMIT) begin
      if (abort_at >= 0 && steps == abort_at) begin
        aborted = 1;
        break;
      end
      out_ready = (int'($urandom_range(0, 99)) < rdy_pct);
      in_valid  = (int'($urandom_range(0, 99)) < vld_pct);
      for (int j = 0; j < OS; j++)
        gamma[j] = (in_valid && steps < len) ? BITS'(gam[steps][j]) : BITS'($urandom);
      if (noise) begin
        start     = ($urandom_range(0, 3) == 0);
        frame_len = LEN_W'($urandom_range(0, 30));
      end
      #1;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_alpha", alpha_out, prev_alpha);
        chk("stall_idx_last", {out_index, out_last}, prev_il);
      end
      chk("busy_in_frame", busy, 1);
      chk("in_ready", in_ready, (beats >= 1 && steps < len) && (!out_valid || out_ready));
      if (out_valid && out_ready) begin
        chk("alpha", alpha_out, eq[beats]);
        chk("out_index", out_index, beats);
        chk("out_last", out_last, beats == len);
        if (beats == 1) c_first = cyc;
        if (beats == len) c_last = cyc;
        beats++;
      end
      if (in_valid && in_ready) steps++;
      prev_stall = out_valid && !out_ready;
      prev_alpha = alpha_out;
      prev_il    = {out_index, out_last};
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;

    if (aborted) begin
      reset = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_index", out_index, 0);
      chk("rst_alpha", alpha_out, 0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("post_abort_quiet", {busy, out_valid}, 0);
      end
    end else begin
      chk("beat_count", beats, len + 1);
      chk("idle_after_frame", {busy, out_valid}, 0);
      if (rdy_pct == 100 && vld_pct == 100 && len >= 1)
        chk("no_bubble", c_last - c_first, len - 1);
    end
  endtask

  task automatic ignored_start(input int len);
    @(negedge clk);
    start = 1'b1;
    frame_len = LEN_W'(len);
    @(negedge clk);
    start = 1'b0;
    chk("ignored_start_busy", busy, 0);
    chk("ignored_start_valid", out_valid, 0);
    @(negedge clk);
    chk("ignored_start_later", {busy, out_valid}, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; frame_len = '0; in_valid = 1'b0;
    out_ready = 1'b0; gamma = '0;
    set_trellis(0);
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_idx_last", {out_index, out_last}, 0);
    chk("reset_alpha", alpha_out, 0);
    reset = 1'b0;

    run_frame(1, 2, 100, 100, 0, -1);
    run_frame(8, 1, 100, 100, 0, -1);
    run_frame(16, 0, 50, 70, 1, -1);
    run_frame(4, 3, 100, 100, 0, -1);
    ignored_start(0);
    ignored_start(1025);
    set_trellis(1);
    run_frame(6, 0, 60, 80, 0, -1);
    run_frame(5, 4, 70, 90, 1, -1);
    set_trellis(0);
    run_frame(10, 0, 100, 100, 0, 5);
    run_frame(3, 0, 100, 100, 0, -1);
    for (int f = 0; f < 4; f++) begin
      set_trellis(int'($urandom_range(0, 1)));
      run_frame(int'($urandom_range(1, 20)), ($urandom_range(0, 1) == 0) ? 0 : 4,
                int'($urandom_range(40, 100)), int'($urandom_range(50, 100)), 1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
